// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory req/ack and decoder valid/ready plus redirect inputs.
// master = fetch unit, slave = memory/decoder side.
interface fetch_unit_if #(
  parameter int unsigned COUNT_W = 32
);
  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_ack;
  logic [31:0]        imem_rdata;
  logic [31:0]        instr;
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               instr_valid;
  logic               instr_ready;
  logic               branch_taken;
  logic [31:0]        branch_target;
  logic               j;
  logic [25:0]        j_target;
  logic [31:0]        pc;
  logic [31:0]        pc_plus4;
  logic               misalign_err;
  logic [COUNT_W-1:0] retired_cnt;

  modport master (
    output imem_req, imem_addr, instr, opcode, funct, instr_valid,
           pc, pc_plus4, misalign_err, retired_cnt,
    input  imem_ack, imem_rdata, instr_ready, branch_taken, branch_target,
           j, j_target
  );

  modport slave (
    input  imem_req, imem_addr, instr, opcode, funct, instr_valid,
           pc, pc_plus4, misalign_err, retired_cnt,
    output imem_ack, imem_rdata, instr_ready, branch_taken, branch_target,
           j, j_target
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: IDLE -> FETCH (req until ack) -> HOLD (valid until ready); min 2 cycles/instr.
// Redirect inputs are sampled only on the accept edge; all outputs are registered or derived from pc/instr.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned COUNT_W  = 32
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_e;

  state_e             state_q;
  logic [31:0]        pc_q;
  logic [31:0]        instr_q;
  logic               imem_req_q;
  logic               instr_valid_q;
  logic               misalign_err_q;
  logic [COUNT_W-1:0] retired_cnt_q;

  logic [31:0]        pc_plus4;
  logic [31:0]        pc_d;
  logic               misalign_d;
  logic               accept;

  assign pc_plus4 = pc_q + 32'd4;
  assign accept   = (state_q == HOLD) && bus.instr_ready;

  // Jump beats branch; a branch target is forced word-aligned and a dropped offset is flagged.
  always_comb begin
    pc_d       = pc_plus4;
    misalign_d = 1'b0;
    if (bus.j) begin
      pc_d = {pc_plus4[31:28], bus.j_target, 2'b00};
    end else if (bus.branch_taken) begin
      pc_d       = {bus.branch_target[31:2], 2'b00};
      misalign_d = |bus.branch_target[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      pc_q           <= RESET_PC;
      instr_q        <= 32'd0;
      imem_req_q     <= 1'b0;
      instr_valid_q  <= 1'b0;
      misalign_err_q <= 1'b0;
      retired_cnt_q  <= '0;
    end else begin
      misalign_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q    <= FETCH;
          imem_req_q <= 1'b1;
        end
        FETCH: begin
          if (bus.imem_ack) begin
            instr_q       <= bus.imem_rdata;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
            state_q       <= HOLD;
          end
        end
        HOLD: begin
          if (accept) begin
            pc_q           <= pc_d;
            misalign_err_q <= misalign_d;
            retired_cnt_q  <= retired_cnt_q + COUNT_W'(1);
            instr_valid_q  <= 1'b0;
            imem_req_q     <= 1'b1;
            state_q        <= FETCH;
          end
        end
        default: begin
          state_q       <= IDLE;
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req     = imem_req_q;
  assign bus.imem_addr    = pc_q;
  assign bus.instr        = instr_q;
  assign bus.opcode       = instr_q[31:26];
  assign bus.funct        = instr_q[5:0];
  assign bus.instr_valid  = instr_valid_q;
  assign bus.pc           = pc_q;
  assign bus.pc_plus4     = pc_plus4;
  assign bus.misalign_err = misalign_err_q;
  assign bus.retired_cnt  = retired_cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 4-bit retire counter so counter wrap is reachable.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  fetch_unit_if #(.COUNT_W(4)) bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .COUNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fetch_word(input logic [31:0] word);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    tick();
    bus.imem_ack   = 1'b0;
  endtask

  task automatic set_redirect(input logic jj, input logic [25:0] jt,
                              input logic br, input logic [31:0] bt);
    bus.j             = jj;
    bus.j_target      = jt;
    bus.branch_taken  = br;
    bus.branch_target = bt;
  endtask

  initial begin
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'd0;
    bus.instr_ready = 1'b0;
    set_redirect(1'b0, 26'd0, 1'b0, 32'd0);

    // Reset with an ack present: reset wins.
    bus.imem_ack = 1'b1;
    tick();
    tick();
    bus.imem_ack = 1'b0;
    chk("rst_req",   32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_pc",    bus.pc, 32'd0);
    chk("rst_p4",    bus.pc_plus4, 32'd4);
    chk("rst_mis",   32'(bus.misalign_err), 32'd0);
    chk("rst_cnt",   32'(bus.retired_cnt), 32'd0);

    // Release: one IDLE bubble, then FETCH at RESET_PC.
    rst = 1'b0;
    chk("idle_req", 32'(bus.imem_req), 32'd0);
    tick();
    chk("fetch_req",  32'(bus.imem_req), 32'd1);
    chk("fetch_addr", bus.imem_addr, 32'd0);
    tick();
    tick();
    chk("fetch_hold_req",  32'(bus.imem_req), 32'd1);
    chk("fetch_hold_addr", bus.imem_addr, 32'd0);

    // add instruction, accepted in first HOLD cycle.
    bus.instr_ready = 1'b1;
    fetch_word(32'h0000_0020);
    chk("add_valid",  32'(bus.instr_valid), 32'd1);
    chk("add_opcode", 32'(bus.opcode), 32'h00);
    chk("add_funct",  32'(bus.funct), 32'h20);
    chk("add_req",    32'(bus.imem_req), 32'd0);
    tick();
    chk("add_valid_drop", 32'(bus.instr_valid), 32'd0);
    chk("add_next_addr",  bus.imem_addr, 32'd4);
    chk("add_req_again",  32'(bus.imem_req), 32'd1);
    chk("add_cnt",        32'(bus.retired_cnt), 32'd1);

    // Stall 5 cycles in HOLD; stray acks must not disturb instr.
    bus.instr_ready = 1'b0;
    fetch_word(32'h8C22_0000);
    chk("lw_opcode", 32'(bus.opcode), 32'h23);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 32'(bus.instr_valid), 32'd1);
      chk("stall_instr", bus.instr, 32'h8C22_0000);
      chk("stall_pc",    bus.pc, 32'd4);
      chk("stall_req",   32'(bus.imem_req), 32'd0);
    end
    bus.imem_ack    = 1'b0;
    bus.instr_ready = 1'b1;
    tick();
    chk("stall_accept_addr", bus.imem_addr, 32'd8);
    chk("stall_accept_cnt",  32'(bus.retired_cnt), 32'd2);

    // Jump from 8 to 0x40.
    fetch_word(32'h0800_0010);
    set_redirect(1'b1, 26'h10, 1'b0, 32'd0);
    tick();
    set_redirect(1'b0, 26'd0, 1'b0, 32'd0);
    chk("j40_addr", bus.imem_addr, 32'h40);
    chk("j40_cnt",  32'(bus.retired_cnt), 32'd3);

    // Aligned branch 0x40 -> 0x100.
    fetch_word(32'h1000_0000);
    set_redirect(1'b0, 26'd0, 1'b1, 32'h100);
    tick();
    set_redirect(1'b0, 26'd0, 1'b0, 32'd0);
    chk("br_addr", bus.imem_addr, 32'h100);
    chk("br_mis",  32'(bus.misalign_err), 32'd0);
    chk("br_p4",   bus.pc_plus4, 32'h104);

    // Misaligned branch 0x100 -> 0x102: lands on 0x100, one-cycle error pulse.
    fetch_word(32'h1000_0000);
    set_redirect(1'b0, 26'd0, 1'b1, 32'h102);
    tick();
    set_redirect(1'b0, 26'd0, 1'b0, 32'd0);
    chk("mis_addr",  bus.imem_addr, 32'h100);
    chk("mis_pulse", 32'(bus.misalign_err), 32'd1);
    chk("mis_cnt",   32'(bus.retired_cnt), 32'd5);
    tick();
    chk("mis_pulse_end", 32'(bus.misalign_err), 32'd0);

    // Branch to 0x1000_0000, then jump+branch together: jump wins.
    fetch_word(32'h1000_0000);
    set_redirect(1'b0, 26'd0, 1'b1, 32'h1000_0000);
    tick();
    chk("br_hi_addr", bus.imem_addr, 32'h1000_0000);
    fetch_word(32'h0800_0010);
    set_redirect(1'b1, 26'h10, 1'b1, 32'h200);
    tick();
    chk("jwin_addr", bus.imem_addr, 32'h1000_0040);
    chk("jwin_mis",  32'(bus.misalign_err), 32'd0);
    chk("jwin_cnt",  32'(bus.retired_cnt), 32'd7);

    // PC wrap: 0xFFFF_FFFC + 4 -> 0.
    fetch_word(32'h1000_0000);
    set_redirect(1'b0, 26'd0, 1'b1, 32'hFFFF_FFFC);
    tick();
    set_redirect(1'b0, 26'd0, 1'b0, 32'd0);
    chk("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
    chk("top_p4",   bus.pc_plus4, 32'h0000_0000);
    fetch_word(32'h0000_0020);
    tick();
    chk("wrap_addr", bus.imem_addr, 32'h0000_0000);
    chk("wrap_cnt",  32'(bus.retired_cnt), 32'd9);

    // Reset during FETCH with ack, then a late ack in IDLE: both ignored.
    tick();
    chk("pre_rst_req", 32'(bus.imem_req), 32'd1);
    rst            = 1'b1;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0000_1234;
    tick();
    rst = 1'b0;
    chk("midrst_req",   32'(bus.imem_req), 32'd0);
    chk("midrst_valid", 32'(bus.instr_valid), 32'd0);
    chk("midrst_instr", bus.instr, 32'd0);
    chk("midrst_cnt",   32'(bus.retired_cnt), 32'd0);
    tick();
    bus.imem_ack = 1'b0;
    chk("lateack_valid", 32'(bus.instr_valid), 32'd0);
    chk("lateack_instr", bus.instr, 32'd0);
    chk("refetch_req",   32'(bus.imem_req), 32'd1);
    chk("refetch_addr",  bus.imem_addr, 32'd0);

    // 16 sequential accepts wrap the 4-bit counter back to 0.
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      fetch_word(32'(i));
      chk("seq_valid", 32'(bus.instr_valid), 32'd1);
      tick();
      chk("seq_cnt", 32'(bus.retired_cnt), 32'((i + 1) % 16));
    end
    chk("seq_final_addr", bus.imem_addr, 32'd64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
